// File: rtl/pipe_skid_reg.sv
// Pipeline stage register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush and control-bit zeroing on bubbles. Optional stall counter under PIPE_SKID_STATS_EN.
module pipe_skid_reg #(
    parameter int unsigned W      = 73,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    // Low CTRL_W bits set; all zero when CTRL_W == 0.
    localparam logic [W-1:0] CtrlMask = {W{1'b1}} >> (W - CTRL_W);

    state_e         state_q, state_d;
    logic [W-1:0]   m_data_q, m_data_d;
    logic [W-1:0]   s_data_q, s_data_d;
    logic           m_valid;
    logic           s_valid;
    logic           in_fire;
    logic           out_fire;

    assign m_valid   = (state_q != StEmpty);
    assign s_valid   = (state_q == StTwo);

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_valid ? m_data_q : (m_data_q & ~CtrlMask);

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        s_data_d = s_data_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    m_data_d = in_data;
                    state_d  = StOne;
                end
            end
            StOne: begin
                if (in_fire && out_fire) begin
                    m_data_d = in_data;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end else if (in_fire) begin
                    s_data_d = in_data;
                    state_d  = StTwo;
                end
            end
            StTwo: begin
                if (out_fire) begin
                    m_data_d = s_data_q;
                    state_d  = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything, including a same-cycle accept: no data load either.
        if (flush) begin
            state_d  = StEmpty;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            m_data_q <= '0;
            s_data_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            s_data_q <= s_data_d;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic [CNT_W-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (W=73, CTRL_W=4, CNT_W=4).
module tb_pipe_skid_reg;

    localparam int unsigned W      = 73;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned CNT_W  = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_tests;
    int n_fail;

    pipe_skid_reg #(
        .W      (W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] BigP = 73'h1_ABCD_EF01_2345_6789_F;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_out_data", {55'b0, out_data}, 128'd0);
        check("reset_in_ready", {127'b0, in_ready}, 128'd1);
        rst = 1'b0;
        step();

        // Streaming: one payload per cycle, each visible the cycle after accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = W'(i);
            check($sformatf("stream_in_ready_%0d", i), {127'b0, in_ready}, 128'd1);
            step();
            check($sformatf("stream_valid_%0d", i), {127'b0, out_valid}, 128'd1);
            check($sformatf("stream_data_%0d", i), {55'b0, out_data}, 128'(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", {127'b0, out_valid}, 128'd0);
        check("stream_drain_data", {55'b0, out_data}, 128'h10);

        // Bubble zeroing: low control bits hidden once the stage empties.
        in_valid = 1'b1;
        in_data  = BigP;
        step();
        in_valid = 1'b0;
        check("bubble_live_data", {55'b0, out_data}, {55'b0, BigP});
        step();
        check("bubble_valid", {127'b0, out_valid}, 128'd0);
        check("bubble_data", {55'b0, out_data}, {55'b0, BigP & ~73'hF});

        // Stall / skid.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 73'hAA;
        step();
        check("skid_a_valid", {127'b0, out_valid}, 128'd1);
        check("skid_a_data", {55'b0, out_data}, 128'hAA);
        check("skid_ready_after_a", {127'b0, in_ready}, 128'd1);
        in_data = 73'hBB;
        step();
        check("skid_ready_after_b", {127'b0, in_ready}, 128'd0);
        check("skid_hold_a", {55'b0, out_data}, 128'hAA);
        in_data = 73'hCC;
        step();
        check("skid_ready_hold", {127'b0, in_ready}, 128'd0);
        check("skid_hold_a2", {55'b0, out_data}, 128'hAA);
        out_ready = 1'b1;
        step();
        check("skid_out_b", {55'b0, out_data}, 128'hBB);
        check("skid_ready_back", {127'b0, in_ready}, 128'd1);
        step();
        check("skid_out_c", {55'b0, out_data}, 128'hCC);
        check("skid_c_valid", {127'b0, out_valid}, 128'd1);
        in_valid = 1'b0;
        step();
        check("skid_empty", {127'b0, out_valid}, 128'd0);

        // Flush in state TWO with a same-cycle push of D.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 73'hAA;
        step();
        in_data = 73'hBB;
        step();
        check("flush_pre_two", {127'b0, in_ready}, 128'd0);
        flush   = 1'b1;
        in_data = 73'hDD;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {127'b0, out_valid}, 128'd0);
        check("flush_ctrl_zero", {124'b0, out_data[3:0]}, 128'd0);
        check("flush_stale_data", {55'b0, out_data}, 128'hA0);
        check("flush_in_ready", {127'b0, in_ready}, 128'd1);
        out_ready = 1'b1;
        step();
        check("flush_no_d", {127'b0, out_valid}, 128'd0);

        // Asynchronous reset mid-cycle while holding two entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 73'h5F;
        step();
        in_data = 73'h6F;
        step();
        in_valid = 1'b0;
        check("areset_pre_two", {127'b0, in_ready}, 128'd0);
        #2;
        rst = 1'b1;
        #1;
        check("areset_out_valid", {127'b0, out_valid}, 128'd0);
        check("areset_out_data", {55'b0, out_data}, 128'd0);
        check("areset_in_ready", {127'b0, in_ready}, 128'd1);
        step();
        rst = 1'b0;
        step();
        check("areset_after_release", {127'b0, out_valid}, 128'd0);

`ifdef PIPE_SKID_STATS_EN
        check("stats_reset", {124'b0, stall_cnt}, 128'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 73'h11;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("stats_count5", {124'b0, stall_cnt}, 128'd5);
        for (int k = 0; k < 15; k++) step();
        check("stats_sat20", {124'b0, stall_cnt}, 128'd15);
        step();
        check("stats_sat_hold", {124'b0, stall_cnt}, 128'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("stats_after_flush", {124'b0, stall_cnt}, 128'd15);
        rst = 1'b1;
        #1;
        check("stats_rst_clear", {124'b0, stall_cnt}, 128'd0);
        step();
        rst = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble-safe control zeroing. It replaces the fixed-field inter-stage latches of the pipelined MIPS-Lite CPU. It carries any packed payload (e.g. ALU result, store data, write register, MEM/WB controls) between stages. It lets a downstream stall propagate upstream one cycle late without losing data.

## Interface
Parameters:
- W, 73: payload width in bits; minimum 1.
- CTRL_W, 4: number of low payload bits that are control strobes; forced to 0 on bubbles; 0 ≤ CTRL_W ≤ W.
- CNT_W, 16: stall counter width; only used with PIPE_SKID_STATS_EN.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discards all held entries.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; depends only on registered state.
- in_data  input  W  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts.
- out_data  output  W  presented payload.
- stall_cnt  output  CNT_W  saturating stall counter; present only with PIPE_SKID_STATS_EN.

## Operation
- Storage:
  - Main slot M (m_valid, m_data).
  - Skid slot S (s_valid, s_data).
- State encoding:
  - EMPTY: neither slot valid.
  - ONE: M valid only.
  - TWO: M and S valid.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Output decode:
  - in_ready = !s_valid.
  - out_valid = m_valid.
  - out_data[W-1:CTRL_W] = m_data[W-1:CTRL_W].
  - out_data[CTRL_W-1:0] = m_valid ? m_data[CTRL_W-1:0] : 0.
- Transitions when flush = 0:
  - EMPTY, in_fire: M <= in_data → ONE; otherwise stay EMPTY.
  - ONE, in_fire & out_fire: M <= in_data → ONE.
  - ONE, out_fire only: → EMPTY.
  - ONE, in_fire only: S <= in_data → TWO.
  - ONE, neither: hold.
  - TWO, out_fire: M <= S → ONE; the new input is not accepted because in_ready = 0.
  - TWO, no out_fire: hold.
- Order is strictly preserved; a payload is never duplicated or dropped except by flush.
- Flush (highest synchronous priority):
  - Next state is EMPTY; m_valid and s_valid are cleared.
  - Any in_fire in the same cycle is discarded; the upstream sees it as accepted.
  - Any out_fire in the same cycle completes normally downstream.
  - Data registers keep stale contents; bubble zeroing hides the control bits.
- Data registers update only on load events; they are not cleared when slots empty.

## Timing
- Reset values, asserted asynchronously and held while rst = 1:
  - m_valid = s_valid = 0 (state EMPTY).
  - m_data = s_data = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1.
  - stall_cnt = 0.
- Reset deassertion mid-transfer: all in-flight payloads are lost; the first edge after release behaves as EMPTY.
- Latency: in_fire at edge N → out_valid = 1 with that data after edge N, i.e. visible in cycle N+1.
- Throughput: one payload per cycle while out_ready = 1.
- Backpressure: in_ready falls one cycle after the first stalled accept (ONE → TWO).
  - Upstream may therefore push exactly one payload into a stalled stage.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- CTRL_W = 0: no zeroing; out_data = m_data.

## Configuration
- PIPE_SKID_STATS_EN defined:
  - stall_cnt port exists.
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at all-ones and is not cleared by flush.
  - Cleared only by rst.
- Not defined: stall_cnt port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst mid-cycle with state TWO → out_valid = 0, out_data = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Streaming: W = 73, CTRL_W = 4, out_ready = 1, push 0x1..0x10 back-to-back → outputs 0x1..0x10 in order, each one cycle after accept, in_ready constantly 1.
- Stall/skid: hold out_ready = 0, push A = 0xAA, B = 0xBB, C = 0xCC continuously → A and B accepted, in_ready = 0 from the cycle after B; release out_ready → outputs A, B, C in order, no loss or duplication.
- Flush: state TWO holding A and B; flush = 1 with in_valid = 1 carrying D → next cycle out_valid = 0, out_data[3:0] = 0, D never appears.
- Bubble zeroing: after draining payload 0x...F, empty stage → out_data[3:0] = 0 while the upper bits keep their stale value.
- Stats (macro on, CNT_W = 4): out_valid with out_ready = 0 for 20 cycles → stall_cnt = 15 and stays 15; flush leaves it at 15; rst clears it to 0.
